product_accumulator: RTL and testbench

//   Accumulates a stream of unsigned 16-bit products from the 8x8 multiplier stage into a

---
 rtl/product_accumulator.sv | 77 +++++++
 tb/tb_product_accumulator.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// product_accumulator: sums N unsigned products into one wide result per output beat,
// with valid/ready handshakes on both the product input and the sum output.
module product_accumulator #(
    parameter int PW    = 16,
    parameter int N     = 8,
    parameter int ACC_W = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             p_valid,
    output logic             p_ready,
    input  logic [PW-1:0]    p_data,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic [ACC_W-1:0] sum_data,
    output logic             sum_ovf,
    output logic             busy
);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             ovf;
    logic [ACC_W:0]   nxt;
    logic             take;

    assign p_ready = state != HOLD;
    assign busy    = state != IDLE;
    assign take    = p_valid && p_ready;
    assign nxt     = {1'b0, acc} + (ACC_W + 1)'(p_data);

    // IDLE keeps acc, cnt and ovf at zero, so its first accept shares the ACCUM datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            sum_data  <= '0;
            sum_ovf   <= 1'b0;
            sum_valid <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            sum_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: if (take) begin
                    acc   <= nxt[ACC_W-1:0];
                    ovf   <= ovf | nxt[ACC_W];
                    cnt   <= cnt + 1'b1;
                    state <= cnt == LAST ? HOLD : ACCUM;
                    if (cnt == LAST) begin
                        sum_data  <= nxt[ACC_W-1:0];
                        sum_ovf   <= ovf | nxt[ACC_W];
                        sum_valid <= 1'b1;
                    end
                end
                HOLD: if (sum_ready) begin
                    state     <= IDLE;
                    acc       <= '0;
                    cnt       <= '0;
                    ovf       <= 1'b0;
                    sum_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: randomized and directed checks of product_accumulator for
// N=8/ACC_W=19, N=2/ACC_W=16 (carry out) and N=1.
module tb_product_accumulator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear_a = 1'b0;
    logic        zero = 1'b0;
    logic        pv[3];
    logic        pr[3];
    logic [15:0] pd[3];
    logic        sr_a = 1'b0, sr_b = 1'b0, sr_c = 1'b0;
    logic        sv_a, sv_b, sv_c, so_a, so_b, so_c, bz_a, bz_b, bz_c;
    logic [18:0] sd_a, sd_c;
    logic [15:0] sd_b;
    int          vecs = 0;
    int          errs = 0;

    always #5 clk = ~clk;

    product_accumulator #(.PW(16), .N(8), .ACC_W(19)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear_a), .p_valid(pv[0]), .p_ready(pr[0]),
        .p_data(pd[0]), .sum_valid(sv_a), .sum_ready(sr_a), .sum_data(sd_a),
        .sum_ovf(so_a), .busy(bz_a));

    product_accumulator #(.PW(16), .N(2), .ACC_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(zero), .p_valid(pv[1]), .p_ready(pr[1]),
        .p_data(pd[1]), .sum_valid(sv_b), .sum_ready(sr_b), .sum_data(sd_b),
        .sum_ovf(so_b), .busy(bz_b));

    product_accumulator #(.PW(16), .N(1), .ACC_W(19)) dut_c (
        .clk(clk), .rst_n(rst_n), .clear(zero), .p_valid(pv[2]), .p_ready(pr[2]),
        .p_data(pd[2]), .sum_valid(sv_c), .sum_ready(sr_c), .sum_data(sd_c),
        .sum_ovf(so_c), .busy(bz_c));

    // Presents one beat and returns on the negedge after the edge that accepted it.
    task automatic send(input int k, input logic [15:0] d);
        int t = 0;
        pv[k] = 1'b1;
        pd[k] = d;
        while (!pr[k] && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        pv[k] = 1'b0;
        vecs++;
        if (t >= 50) begin
            errs++;
            $display("FAIL send%0d_timeout: p_ready got 0 for 50 cycles, want 1", k);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        #1;
        vecs++; if (sv_a !== 1'b0) begin errs++; $display("FAIL rst_sum_valid: got %b want 0", sv_a); end
        vecs++; if (sd_a !== 19'd0) begin errs++; $display("FAIL rst_sum_data: got %0h want 0", sd_a); end
        vecs++; if (so_a !== 1'b0) begin errs++; $display("FAIL rst_sum_ovf: got %b want 0", so_a); end
        vecs++; if (bz_a !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b want 0", bz_a); end
        vecs++; if ({sv_b, sv_c} !== 2'b00) begin errs++; $display("FAIL rst_bc_valid: got %b want 00", {sv_b, sv_c}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vecs++; if (pr[0] !== 1'b1) begin errs++; $display("FAIL rst_p_ready: got %b want 1", pr[0]); end
    endtask

    task automatic test_back_to_back;
        longint tot = 0;
        sr_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vecs++; if (pr[0] !== 1'b1) begin errs++; $display("FAIL b2b_p_ready[%0d]: got %b want 1", i, pr[0]); end
            pv[0] = 1'b1;
            pd[0] = 16'hFE01;
            tot += 64'hFE01;
            @(negedge clk);
        end
        pv[0] = 1'b0;
        vecs++; if (sv_a !== 1'b1) begin errs++; $display("FAIL b2b_valid: got %b want 1", sv_a); end
        vecs++; if (sd_a !== 19'(tot)) begin errs++; $display("FAIL b2b_sum: got %0h want %0h", sd_a, 19'(tot)); end
        vecs++; if (so_a !== (tot >= 524288)) begin errs++; $display("FAIL b2b_ovf: got %b want %b", so_a, tot >= 524288); end
        vecs++; if (pr[0] !== 1'b0) begin errs++; $display("FAIL b2b_hold_ready: got %b want 0", pr[0]); end
        @(negedge clk);
        vecs++; if (sv_a !== 1'b0) begin errs++; $display("FAIL b2b_valid_drop: got %b want 0", sv_a); end
        vecs++; if (pr[0] !== 1'b1) begin errs++; $display("FAIL b2b_ready_back: got %b want 1", pr[0]); end
        vecs++; if (bz_a !== 1'b0) begin errs++; $display("FAIL b2b_busy: got %b want 0", bz_a); end
    endtask

    task automatic test_stall;
        longint tot = 0;
        sr_a = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            idle($urandom_range(0, 2));
            send(0, 16'(i));
            tot += i;
        end
        for (int c = 0; c < 5; c++) begin
            pv[0] = 1'b1;
            pd[0] = 16'd99;
            vecs++; if (sv_a !== 1'b1) begin errs++; $display("FAIL stall_valid[%0d]: got %b want 1", c, sv_a); end
            vecs++; if (sd_a !== 19'(tot)) begin errs++; $display("FAIL stall_sum[%0d]: got %0d want %0d", c, sd_a, tot); end
            vecs++; if (pr[0] !== 1'b0) begin errs++; $display("FAIL stall_ready[%0d]: got %b want 0", c, pr[0]); end
            vecs++; if (bz_a !== 1'b1) begin errs++; $display("FAIL stall_busy[%0d]: got %b want 1", c, bz_a); end
            @(negedge clk);
        end
        pv[0] = 1'b0;
        sr_a = 1'b1;
        #1;
        vecs++; if (pr[0] !== 1'b0) begin errs++; $display("FAIL stall_ready_comb: got %b want 0", pr[0]); end
        @(negedge clk);
        vecs++; if (sv_a !== 1'b0) begin errs++; $display("FAIL stall_taken: got %b want 0", sv_a); end
        vecs++; if (bz_a !== 1'b0) begin errs++; $display("FAIL stall_busy_end: got %b want 0", bz_a); end
    endtask

    task automatic test_clear;
        longint tot = 0;
        sr_a = 1'b1;
        repeat (4) send(0, 16'd100);
        pv[0] = 1'b1;
        pd[0] = 16'd100;
        clear_a = 1'b1;
        @(negedge clk);
        clear_a = 1'b0;
        pv[0] = 1'b0;
        vecs++; if (bz_a !== 1'b0) begin errs++; $display("FAIL clr_busy: got %b want 0", bz_a); end
        vecs++; if (sv_a !== 1'b0) begin errs++; $display("FAIL clr_valid: got %b want 0", sv_a); end
        repeat (8) begin
            send(0, 16'd2);
            tot += 2;
        end
        vecs++; if (sv_a !== 1'b1) begin errs++; $display("FAIL clr_after_valid: got %b want 1", sv_a); end
        vecs++; if (sd_a !== 19'(tot)) begin errs++; $display("FAIL clr_after_sum: got %0d want %0d", sd_a, tot); end
        @(negedge clk);
        sr_a = 1'b0;
        repeat (8) send(0, 16'd3);
        vecs++; if (sv_a !== 1'b1) begin errs++; $display("FAIL clr_hold_valid: got %b want 1", sv_a); end
        clear_a = 1'b1;
        sr_a = 1'b1;
        @(negedge clk);
        clear_a = 1'b0;
        sr_a = 1'b0;
        vecs++; if (sv_a !== 1'b0) begin errs++; $display("FAIL clr_hold_drop: got %b want 0", sv_a); end
        vecs++; if (pr[0] !== 1'b1) begin errs++; $display("FAIL clr_hold_ready: got %b want 1", pr[0]); end
    endtask

    task automatic test_async_reset;
        longint tot = 0;
        sr_a = 1'b0;
        repeat (5) send(0, 16'd7);
        #2 rst_n = 1'b0;
        #1;
        vecs++; if (bz_a !== 1'b0) begin errs++; $display("FAIL arst_accum_busy: got %b want 0", bz_a); end
        vecs++; if (sd_a !== 19'd0) begin errs++; $display("FAIL arst_accum_sum: got %0d want 0", sd_a); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) send(0, 16'd9);
        vecs++; if (sd_a !== 19'd72) begin errs++; $display("FAIL arst_mid_sum: got %0d want 72", sd_a); end
        #2 rst_n = 1'b0;
        #1;
        vecs++; if (sv_a !== 1'b0) begin errs++; $display("FAIL arst_hold_valid: got %b want 0", sv_a); end
        vecs++; if (sd_a !== 19'd0) begin errs++; $display("FAIL arst_hold_sum: got %0d want 0", sd_a); end
        vecs++; if (bz_a !== 1'b0) begin errs++; $display("FAIL arst_hold_busy: got %b want 0", bz_a); end
        @(negedge clk);
        rst_n = 1'b1;
        sr_a = 1'b1;
        repeat (8) begin
            send(0, 16'd1);
            tot += 1;
        end
        vecs++; if (sd_a !== 19'(tot) || sv_a !== 1'b1) begin errs++; $display("FAIL arst_next_sum: got %0d/%b want %0d/1", sd_a, sv_a, tot); end
        @(negedge clk);
        sr_a = 1'b0;
    endtask

    task automatic test_random;
        for (int s = 0; s < 15; s++) begin
            longint tot = 0;
            int t = 0;
            logic r;
            for (int j = 0; j < 8; j++) begin
                logic [15:0] d;
                d = 16'($urandom);
                idle($urandom_range(0, 2));
                send(0, d);
                tot += d;
            end
            do begin
                vecs++; if (sv_a !== 1'b1) begin errs++; $display("FAIL rnd_valid[%0d]: got %b want 1", s, sv_a); end
                vecs++; if (sd_a !== 19'(tot)) begin errs++; $display("FAIL rnd_sum[%0d]: got %0d want %0d", s, sd_a, 19'(tot)); end
                vecs++; if (so_a !== (tot >= 524288)) begin errs++; $display("FAIL rnd_ovf[%0d]: got %b want %b", s, so_a, tot >= 524288); end
                r = $urandom_range(0, 3) != 0;
                sr_a = r;
                @(negedge clk);
                t++;
            end while (!r && t < 40);
            sr_a = 1'b0;
            vecs++; if (sv_a !== 1'b0) begin errs++; $display("FAIL rnd_taken[%0d]: got %b want 0", s, sv_a); end
        end
    endtask

    task automatic test_overflow;
        longint tot;
        sr_b = 1'b1;
        send(1, 16'hFE01);
        send(1, 16'hFE01);
        tot = 2 * 64'hFE01;
        vecs++; if (sv_b !== 1'b1) begin errs++; $display("FAIL ovf_valid: got %b want 1", sv_b); end
        vecs++; if (sd_b !== 16'(tot)) begin errs++; $display("FAIL ovf_sum: got %0h want %0h", sd_b, 16'(tot)); end
        vecs++; if (so_b !== 1'b1) begin errs++; $display("FAIL ovf_flag: got %b want 1", so_b); end
        @(negedge clk);
        send(1, 16'd1);
        send(1, 16'd2);
        vecs++; if (sd_b !== 16'd3) begin errs++; $display("FAIL ovf_next_sum: got %0d want 3", sd_b); end
        vecs++; if (so_b !== 1'b0) begin errs++; $display("FAIL ovf_next_flag: got %b want 0", so_b); end
        @(negedge clk);
        for (int s = 0; s < 10; s++) begin
            logic [15:0] d0, d1;
            d0 = 16'($urandom);
            d1 = 16'($urandom);
            send(1, d0);
            send(1, d1);
            tot = longint'(d0) + longint'(d1);
            vecs++; if (sd_b !== 16'(tot)) begin errs++; $display("FAIL ovf_rnd_sum[%0d]: got %0h want %0h", s, sd_b, 16'(tot)); end
            vecs++; if (so_b !== (tot >= 65536)) begin errs++; $display("FAIL ovf_rnd_flag[%0d]: got %b want %b", s, so_b, tot >= 65536); end
            @(negedge clk);
        end
        vecs++; if (sv_b !== 1'b0 || bz_b !== 1'b0) begin errs++; $display("FAIL ovf_end: got valid %b busy %b want 0 0", sv_b, bz_b); end
    endtask

    task automatic test_single;
        sr_c = 1'b1;
        pv[2] = 1'b1;
        pd[2] = 16'd7;
        @(negedge clk);
        pd[2] = 16'd9;
        vecs++; if (sv_c !== 1'b1 || sd_c !== 19'd7) begin errs++; $display("FAIL n1_first: got %b/%0d want 1/7", sv_c, sd_c); end
        vecs++; if (pr[2] !== 1'b0 || bz_c !== 1'b1) begin errs++; $display("FAIL n1_first_hold: got ready %b busy %b want 0 1", pr[2], bz_c); end
        @(negedge clk);
        vecs++; if (sv_c !== 1'b0 || pr[2] !== 1'b1) begin errs++; $display("FAIL n1_gap: got valid %b ready %b want 0 1", sv_c, pr[2]); end
        @(negedge clk);
        pv[2] = 1'b0;
        vecs++; if (sv_c !== 1'b1 || sd_c !== 19'd9 || so_c !== 1'b0) begin errs++; $display("FAIL n1_second: got %b/%0d/%b want 1/9/0", sv_c, sd_c, so_c); end
        vecs++; if (pr[2] !== 1'b0) begin errs++; $display("FAIL n1_second_hold: got %b want 0", pr[2]); end
        @(negedge clk);
        vecs++; if (sv_c !== 1'b0 || bz_c !== 1'b0) begin errs++; $display("FAIL n1_end: got valid %b busy %b want 0 0", sv_c, bz_c); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            pv[k] = 1'b0;
            pd[k] = 16'd0;
        end
        test_reset;
        test_back_to_back;
        test_stall;
        test_clear;
        test_async_reset;
        test_random;
        test_overflow;
        test_single;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
